// File: rtl/dlp_pkg.sv
// Shared constants and control-word typedef for the DLP datapath.
package dlp_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LANES  = 32;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned VEC_W  = DATA_W * LANES;

    // Bit positions inside the ctl word
    localparam logic [0:0] FIRST = 1'b0;
    localparam logic [0:0] LAST  = 1'b1;

    typedef logic [1:0] ctl_t;

endpackage

// File: rtl/pe_adder_tree.sv
// Combinational LANES-input reduction; every level wraps modulo 2^RES_W.
module pe_adder_tree #(
    parameter int unsigned LANES = 32,
    parameter int unsigned RES_W = 32
) (
    input  logic [LANES*RES_W-1:0] operands_i,
    output logic [RES_W-1:0]       sum_o
);

    // Pairwise tree: each pass halves the live node count (LANES must be a power of two)
    always_comb begin
        logic [RES_W-1:0] node [LANES];
        for (int i = 0; i < LANES; i++) begin
            node[i] = operands_i[i*RES_W +: RES_W];
        end
        for (int w = LANES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                node[i] = node[2*i] + node[2*i+1];
            end
        end
        sum_o = node[0];
    end

endmodule

// File: rtl/dlp_parallel_pe.sv
// Vector dot-product PE: lane multipliers, adder tree and instruction accumulator,
// three register stages from input sample to result.
module dlp_parallel_pe
    import dlp_pkg::*;
#(
    parameter int unsigned DATA_W = dlp_pkg::DATA_W,
    parameter int unsigned LANES  = dlp_pkg::LANES,
    parameter int unsigned RES_W  = dlp_pkg::RES_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W*LANES-1:0] neuron,
    input  logic [DATA_W*LANES-1:0] weight,
    input  ctl_t                    ctl,
    input  logic                    vld_i,
    output logic [RES_W-1:0]        result,
    output logic                    vld_o
);

    logic [LANES*RES_W-1:0] prod_d;
    logic [LANES*RES_W-1:0] prod_q;
    logic                   s1_vld_q;
    ctl_t                   s1_ctl_q;
    logic [RES_W-1:0]       sum_s;
    logic [RES_W-1:0]       sum_q;
    logic                   s2_vld_q;
    ctl_t                   s2_ctl_q;
    logic [RES_W-1:0]       acc_d;
    logic [RES_W-1:0]       acc_q;
    logic [RES_W-1:0]       result_d;
    logic [RES_W-1:0]       result_q;
    logic                   vld_o_d;
    logic                   vld_o_q;

    // Lane multipliers: the low RES_W bits of the extended product equal the signed product
    always_comb begin
        logic [RES_W-1:0] n_ext;
        logic [RES_W-1:0] w_ext;
        prod_d = '0;
        for (int i = 0; i < LANES; i++) begin
            n_ext = {{(RES_W-DATA_W){neuron[i*DATA_W+DATA_W-1]}}, neuron[i*DATA_W +: DATA_W]};
            w_ext = {{(RES_W-DATA_W){weight[i*DATA_W+DATA_W-1]}}, weight[i*DATA_W +: DATA_W]};
            prod_d[i*RES_W +: RES_W] = n_ext * w_ext;
        end
    end

    // Stage 1: products and tag; data held across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_ctl_q <= 2'b00;
        end else begin
            s1_vld_q <= vld_i;
            if (vld_i) begin
                prod_q   <= prod_d;
                s1_ctl_q <= ctl;
            end
        end
    end

    pe_adder_tree #(
        .LANES(LANES),
        .RES_W(RES_W)
    ) u_adder_tree (
        .operands_i(prod_q),
        .sum_o     (sum_s)
    );

    // Stage 2: reduced partial sum and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            s2_vld_q <= 1'b0;
            s2_ctl_q <= 2'b00;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                sum_q    <= sum_s;
                s2_ctl_q <= s1_ctl_q;
            end
        end
    end

    // Accumulator next state; a final beat publishes the post-update value
    always_comb begin
        acc_d    = acc_q;
        result_d = result_q;
        vld_o_d  = 1'b0;
        if (s2_vld_q) begin
            if (s2_ctl_q[FIRST]) begin
                acc_d = sum_q;
            end else begin
                acc_d = acc_q + sum_q;
            end
            if (s2_ctl_q[LAST]) begin
                result_d = acc_d;
                vld_o_d  = 1'b1;
            end else begin
                result_d = result_q;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Stage 3: accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            result_q <= '0;
            vld_o_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
            vld_o_q  <= vld_o_d;
        end
    end

    assign result = result_q;
    assign vld_o  = vld_o_q;

endmodule

// File: tb/tb_dlp_parallel_pe.sv
// Directed bench for dlp_parallel_pe: latency, signed lanes, framing, overflow, reset.
module tb_dlp_parallel_pe;

    localparam int VW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [VW-1:0] neuron;
    logic [VW-1:0] weight;
    logic [1:0]    ctl;
    logic          vld_i;
    logic [31:0]   result;
    logic          vld_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    dlp_parallel_pe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .neuron(neuron),
        .weight(weight),
        .ctl   (ctl),
        .vld_i (vld_i),
        .result(result),
        .vld_o (vld_o)
    );

    always #5 clk = ~clk;

    // Record every result pulse, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (vld_o === 1'b1) got_q.push_back(result);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // First cnt lanes hold v, remaining lanes zero
    function automatic logic [VW-1:0] lanes(input logic [15:0] v, input int cnt);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < cnt; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    // Reference 32-bit wrapping dot product
    function automatic logic [31:0] dot(input logic [VW-1:0] n, input logic [VW-1:0] w);
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic [31:0]        s;
        s = 32'd0;
        for (int i = 0; i < 32; i++) begin
            a = $signed(n[i*16 +: 16]);
            b = $signed(w[i*16 +: 16]);
            s = s + 32'(a * b);
        end
        return s;
    endfunction

    task automatic send(input logic [VW-1:0] n, input logic [VW-1:0] w, input logic [1:0] c);
        @(negedge clk);
        neuron = n;
        weight = w;
        ctl    = c;
        vld_i  = 1'b1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            vld_i = 1'b0;
            ctl   = 2'b00;
        end
    endtask

    task automatic check_results(input string name);
        idle(6);
        tests_run++;
        if (got_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s pulse count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                tests_run++;
                if (got_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL %s result[%0d]: got %h expected %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        vld_i  = 1'b0;
        ctl    = 2'b00;
        neuron = '0;
        weight = '0;
        repeat (3) @(negedge clk);
        tests_run += 2;
        if (result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset result: got %h expected 00000000", result);
        end
        if (vld_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset vld_o: got %b expected 0", vld_o);
        end
        rst_n = 1'b1;
        idle(3);
        tests_run++;
        if (got_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset idle pulses: got %0d expected 0", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_single_latency();
        send(lanes(16'h0001, 32), lanes(16'h0002, 32), 2'b11);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #2;
            tests_run++;
            if (vld_o !== (k == 3)) begin
                tests_failed++;
                $display("FAIL latency vld_o edge %0d: got %b expected %b", k, vld_o, (k == 3));
            end
            if (k >= 3) begin
                tests_run++;
                if (result !== 32'd64) begin
                    tests_failed++;
                    $display("FAIL single result edge %0d: got %h expected 00000040", k, result);
                end
            end
            if (k == 1) begin
                vld_i = 1'b0;
                ctl   = 2'b00;
            end
        end
        exp_q.push_back(32'd64);
        check_results("single_beat");
    endtask

    task automatic test_signed();
        send(lanes(16'hFFFF, 1), lanes(16'h0003, 1), 2'b11);
        exp_q.push_back(32'hFFFF_FFFD);
        check_results("signed");
    endtask

    task automatic test_multi_beat();
        send(lanes(16'h0001, 32), lanes(16'h0001, 32), 2'b01);
        send(lanes(16'h0001, 32), lanes(16'h0001, 32), 2'b00);
        send(lanes(16'h0001, 32), lanes(16'h0001, 32), 2'b00);
        send(lanes(16'h0001, 32), lanes(16'h0001, 32), 2'b10);
        exp_q.push_back(32'd128);
        check_results("multi_beat");
    endtask

    task automatic test_back_to_back();
        int            len [4] = '{1, 3, 8, 128};
        logic [VW-1:0] n;
        logic [VW-1:0] w;
        logic [31:0]   acc;
        for (int k = 0; k < 4; k++) begin
            acc = 32'd0;
            for (int b = 0; b < len[k]; b++) begin
                for (int j = 0; j < 16; j++) begin
                    n[j*32 +: 32] = $urandom;
                    w[j*32 +: 32] = $urandom;
                end
                acc = acc + dot(n, w);
                send(n, w, {(b == len[k] - 1), (b == 0)});
                if (k == 3 && b == 64) idle(1);
            end
            exp_q.push_back(acc);
            if (k == 0 || k == 2) idle(1);
        end
        check_results("back_to_back");
    endtask

    task automatic test_overflow();
        send(lanes(16'h8000, 32), lanes(16'h8000, 32), 2'b11);
        send(lanes(16'h8000, 16), lanes(16'h8000, 16), 2'b11);
        send(lanes(16'h8000, 1),  lanes(16'h8000, 1),  2'b11);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h4000_0000);
        check_results("overflow");
    endtask

    task automatic test_reset_mid();
        send(lanes(16'h0001, 32), lanes(16'h0001, 32), 2'b01);
        send(lanes(16'h0001, 32), lanes(16'h0001, 32), 2'b00);
        @(negedge clk);
        vld_i = 1'b0;
        ctl   = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        tests_run += 3;
        if (got_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid pulses: got %0d expected 0", got_q.size());
        end
        if (result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid result: got %h expected 00000000", result);
        end
        if (vld_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid vld_o: got %b expected 0", vld_o);
        end
        got_q.delete();
        send(lanes(16'h0002, 32), lanes(16'h0003, 32), 2'b01);
        send(lanes(16'h0002, 32), lanes(16'h0003, 32), 2'b10);
        exp_q.push_back(32'd384);
        check_results("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_signed();
        test_multi_beat();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
